alu32_div_seq: RTL and testbench

Iterative 32-bit integer divider controller. It owns one ALU32 instance and sequences it, one subtract per cycle, to produce quotient and remainder with restoring division. Optional signed mode reuses the same ALU for operand and result negation, as 0 - x with ALU ctl=01. It sits beside the main ALU path as the multi-cycle DIV/REM unit, with a start/done handshake toward the issue logic.

---
 rtl/alu32_div_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu32_div_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_div_seq.sv
// Iterative 32-bit restoring divider (DIV/REM unit) built around a single ALU32.
// Latency: 1 cycle for divide-by-zero, 33 cycles unsigned, 37 cycles signed (edge that enters DONE).
// Backpressure: start is only taken while ready=1; starts in any other state are dropped, never queued.

// Small 32-bit ALU: ctl 00 add, 01 subtract (carry=1 means no borrow), 10 and, 11 or.
module alu32 (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [1:0]  ctl,
    output logic [31:0] sum,
    output logic        carry
);

    // Pure combinational datapath; subtract is op1 + ~op2 + 1 so carry doubles as not-borrow.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        case (ctl)
            2'b00:   {carry, sum} = {1'b0, op1} + {1'b0, op2};
            2'b01:   {carry, sum} = {1'b0, op1} + {1'b0, ~op2} + 33'd1;
            2'b10:   sum = op1 & op2;
            default: sum = op1 | op2;
        endcase
    end

endmodule

module alu32_div_seq #(
    parameter int SIGNED_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_A = 3'd1,
        NEG_B = 3'd2,
        CALC  = 3'd3,
        NEG_Q = 3'd4,
        NEG_R = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state;
    // Q doubles as the working dividend A: it is loaded at accept, optionally negated,
    // then shifted out MSB-first while quotient bits shift in at the bottom.
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] b;
    logic [4:0]  cnt;
    logic        s;
    logic        sa;
    logic        sb;

    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_sum;
    logic        alu_carry;
    logic [1:0]  alu_ctl;
    logic [31:0] r_sh;
    logic        take;
    logic        sg_eff;

    // Every step (negate or trial subtract) is a subtraction, so ctl never changes.
    assign alu_ctl = 2'b01;
    assign sg_eff  = sgn & (SIGNED_EN != 0);
    assign r_sh    = {r[30:0], q[31]};
    // R[31] set means the true shifted remainder exceeds 2^32 > B, so subtract regardless of carry.
    assign take    = r[31] | alu_carry;

    assign ready = (state == IDLE);
    assign done  = (state == DONE);
    assign busy  = (state != IDLE) && (state != DONE);

    // ALU operand steering: negations are computed as 0 - x, CALC does the trial subtract.
    always_comb begin
        alu_op1 = '0;
        alu_op2 = '0;
        case (state)
            NEG_A:   alu_op2 = q;
            NEG_B:   alu_op2 = b;
            CALC: begin
                alu_op1 = r_sh;
                alu_op2 = b;
            end
            NEG_Q:   alu_op2 = q;
            NEG_R:   alu_op2 = r;
            default: begin
                alu_op1 = '0;
                alu_op2 = '0;
            end
        endcase
    end

    alu32 u_alu (
        .op1   (alu_op1),
        .op2   (alu_op2),
        .ctl   (alu_ctl),
        .sum   (alu_sum),
        .carry (alu_carry)
    );

    // Sequencer and datapath registers; results land in quo/rem on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            b     <= '0;
            cnt   <= '0;
            s     <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dz    <= 1'b0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q   <= dividend;
                        b   <= divisor;
                        r   <= '0;
                        cnt <= '0;
                        s   <= sg_eff;
                        sa  <= sg_eff & dividend[31];
                        sb  <= sg_eff & divisor[31];
                        dz  <= 1'b0;
                        if (divisor == 32'd0) begin
                            dz    <= 1'b1;
                            quo   <= 32'hFFFF_FFFF;
                            rem   <= dividend;
                            state <= DONE;
                        end else if (sg_eff) begin
                            state <= NEG_A;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                NEG_A: begin
                    if (sa) q <= alu_sum;
                    state <= NEG_B;
                end
                NEG_B: begin
                    if (sb) b <= alu_sum;
                    state <= CALC;
                end
                CALC: begin
                    r   <= take ? alu_sum : r_sh;
                    q   <= {q[30:0], take};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        if (s) begin
                            state <= NEG_Q;
                        end else begin
                            quo   <= {q[30:0], take};
                            rem   <= take ? alu_sum : r_sh;
                            state <= DONE;
                        end
                    end
                end
                NEG_Q: begin
                    if (sa ^ sb) q <= alu_sum;
                    state <= NEG_R;
                end
                NEG_R: begin
                    quo   <= q;
                    rem   <= sa ? alu_sum : r;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_div_seq.sv
// Bench for alu32_div_seq: scoreboard of expected results filled at issue, drained at done.
// Latency is counted in edges, the accept edge being edge 1.
// Busy-time start pulses carry garbage operands so any wrongly accepted start corrupts results.
module tb_alu32_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] quo;
    logic [31:0] rem;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q[$];

    alu32_div_seq #(.SIGNED_EN(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sgn      (sgn),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .quo      (quo),
        .rem      (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference via sign-magnitude native division (overflow case handled by unsigned magnitudes).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic sg);
        exp_t        e;
        logic [31:0] ma;
        logic [31:0] md;
        if (d == 32'd0) begin
            e.quo = 32'hFFFF_FFFF;
            e.rem = a;
            e.dz  = 1'b1;
            e.lat = 8'd1;
        end else begin
            ma    = (sg && a[31]) ? 32'(32'd0 - a) : a;
            md    = (sg && d[31]) ? 32'(32'd0 - d) : d;
            e.quo = ma / md;
            e.rem = ma % md;
            if (sg && (a[31] ^ d[31])) e.quo = 32'(32'd0 - e.quo);
            if (sg && a[31])           e.rem = 32'(32'd0 - e.rem);
            e.dz  = 1'b0;
            e.lat = sg ? 8'd37 : 8'd33;
        end
        return e;
    endfunction

    // Issue one operation (waiting for ready first), push its expectation, wait for done.
    // With noise set, random start pulses with garbage operands are driven while it runs.
    task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic sg,
                         input bit noise, output int lat, output bit seen, output bit rdy_early);
        int k;
        k = 0;
        while (!ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        sb_q.push_back(model(a, d, sg));
        start    = 1'b1;
        dividend = a;
        divisor  = d;
        sgn      = sg;
        seen      = 1'b0;
        rdy_early = 1'b0;
        lat       = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
            if (ready) rdy_early = 1'b1;
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            dividend = $urandom;
            divisor  = $urandom_range(0, 3);
            sgn      = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sgn = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ready, busy, done, dz} !== 4'b1000 || quo !== 32'd0 || rem !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: rdy/busy/done/dz=%b quo=%h rem=%h, need 1000 0 0",
                     {ready, busy, done, dz}, quo, rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [31:0] ta[6] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] td[6] = '{32'd7, 32'h8000_0001, 32'd9, 32'd1, 32'd13, 32'hFFFF_FFFF};
        int lat;
        bit seen, early;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, d;
            a = (i < 6) ? ta[i] : $urandom;
            d = (i < 6) ? td[i] : ($urandom >> $urandom_range(0, 30)) | 32'd1;
            do_op(a, d, 1'b0, 1'b0, lat, seen, early);
            e = sb_q.pop_front();
            total++;
            if (!seen || lat != int'(e.lat) || early || quo !== e.quo || rem !== e.rem || dz !== e.dz) begin
                bad++;
                $display("FAIL unsigned[%0d] %h/%h: seen=%0d lat=%0d early_rdy=%0d quo=%h rem=%h dz=%b, need lat=%0d quo=%h rem=%h dz=%b",
                         i, a, d, seen, lat, early, quo, rem, dz, e.lat, e.quo, e.rem, e.dz);
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta[6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h7FFF_FFFF};
        logic [31:0] td[6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd7, 32'h8000_0000};
        int lat;
        bit seen, early;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, d;
            a = (i < 6) ? ta[i] : $urandom;
            d = (i < 6) ? td[i] : $urandom | 32'd1;
            do_op(a, d, 1'b1, 1'b0, lat, seen, early);
            e = sb_q.pop_front();
            total++;
            if (!seen || lat != int'(e.lat) || quo !== e.quo || rem !== e.rem || dz !== e.dz) begin
                bad++;
                $display("FAIL signed[%0d] %h/%h: seen=%0d lat=%0d quo=%h rem=%h dz=%b, need lat=%0d quo=%h rem=%h dz=%b",
                         i, a, d, seen, lat, quo, rem, dz, e.lat, e.quo, e.rem, e.dz);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit seen, early;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = (i == 2) ? 32'h8000_1234 : 32'h0000_1234;
            do_op(a, 32'd0, 1'(i & 1), 1'b0, lat, seen, early);
            e = sb_q.pop_front();
            total++;
            if (!seen || lat != int'(e.lat) || quo !== e.quo || rem !== e.rem || dz !== e.dz) begin
                bad++;
                $display("FAIL div_zero[%0d]: seen=%0d lat=%0d quo=%h rem=%h dz=%b, need lat=%0d quo=%h rem=%h dz=%b",
                         i, seen, lat, quo, rem, dz, e.lat, e.quo, e.rem, e.dz);
            end
            // dz must clear on the next accept
            if (i == 2) begin
                do_op(32'd50, 32'd5, 1'b0, 1'b0, lat, seen, early);
                e = sb_q.pop_front();
                total++;
                if (!seen || dz !== 1'b0 || quo !== e.quo || rem !== e.rem) begin
                    bad++;
                    $display("FAIL dz_clear: seen=%0d dz=%b quo=%h rem=%h, need dz=0 quo=%h rem=%h",
                             seen, dz, quo, rem, e.quo, e.rem);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit seen, early;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, d;
            logic sg;
            a  = $urandom;
            d  = $urandom_range(1, 1000);
            sg = 1'(i & 1);
            do_op(a, d, sg, 1'b1, lat, seen, early);
            // garbage start during the DONE cycle must be dropped
            start    = 1'b1;
            dividend = 32'h1;
            divisor  = 32'h0;
            sgn      = 1'b0;
            e = sb_q.pop_front();
            total++;
            if (!seen || lat != int'(e.lat) || quo !== e.quo || rem !== e.rem || dz !== e.dz) begin
                bad++;
                $display("FAIL b2b_noise[%0d] %h/%h s=%0d: seen=%0d lat=%0d quo=%h rem=%h dz=%b, need lat=%0d quo=%h rem=%h dz=%b",
                         i, a, d, sg, seen, lat, quo, rem, dz, e.lat, e.quo, e.rem, e.dz);
            end
            @(posedge clk); #1;
            start = 1'b0;
            total++;
            if (ready !== 1'b1 || done !== 1'b0 || dz !== e.dz || quo !== e.quo) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: ready=%b done=%b dz=%b quo=%h, need ready=1 done=0 dz=%b quo=%h",
                         i, ready, done, dz, quo, e.dz, e.quo);
            end
        end
        // first ready cycle: a fresh issue must be accepted immediately (latency 33)
        do_op(32'd1000, 32'd3, 1'b0, 1'b0, lat, seen, early);
        e = sb_q.pop_front();
        total++;
        if (!seen || lat != int'(e.lat) || quo !== e.quo || rem !== e.rem) begin
            bad++;
            $display("FAIL b2b_accept: seen=%0d lat=%0d quo=%h rem=%h, need lat=%0d quo=%h rem=%h",
                     seen, lat, quo, rem, e.lat, e.quo, e.rem);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit seen, early;
        exp_t e;
        start    = 1'b1;
        dividend = 32'd12345;
        divisor  = 32'd11;
        sgn      = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || quo !== 32'd0 || rem !== 32'd0 || dz !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: ready=%b busy=%b done=%b quo=%h rem=%h dz=%b, need 1 0 0 0 0 0",
                     ready, busy, done, quo, rem, dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'd9, 32'd3, 1'b0, 1'b0, lat, seen, early);
        e = sb_q.pop_front();
        total++;
        if (!seen || lat != int'(e.lat) || quo !== 32'd3 || rem !== 32'd0) begin
            bad++;
            $display("FAIL after_abort 9/3: seen=%0d lat=%0d quo=%h rem=%h, need lat=33 quo=3 rem=0",
                     seen, lat, quo, rem);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
